// File: rtl/aes_decrypt_ctrl_if.sv
// Bus between the AES-128 decrypt controller and its surroundings: the user request and
// result, plus the round interface to the external inverse-round datapath and key expansion.
interface aes_decrypt_ctrl_if;
  logic             start;
  logic [15:0][7:0] cipher_in;
  logic [15:0][7:0] key_in;
  logic [15:0][7:0] round_data;
  logic [15:0][7:0] round_key;
  logic [3:0]       round_rc;
  logic [15:0][7:0] round_out;
  logic [15:0][7:0] round_keyout;
  logic [15:0][7:0] final_out;
  logic             busy;
  logic             done;
  logic [15:0][7:0] plain_out;

  // Controller side
  modport slave (
    input  start, cipher_in, key_in, round_out, round_keyout, final_out,
    output round_data, round_key, round_rc, busy, done, plain_out
  );

  // User plus datapath side
  modport master (
    output start, cipher_in, key_in, round_out, round_keyout, final_out,
    input  round_data, round_key, round_rc, busy, done, plain_out
  );
endinterface

// File: rtl/aes_decrypt_ctrl.sv
// AES-128 decryption sequencer. Holds the running state and round key, steps the external
// inverse-round datapath once per cycle, and captures the final-round result.
module aes_decrypt_ctrl #(
  parameter int unsigned NROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  aes_decrypt_ctrl_if.slave bus
);

  localparam logic [3:0] RndInit = 4'(NROUNDS);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [15:0][7:0] r_data;
  logic [15:0][7:0] w_data_d;
  logic [15:0][7:0] r_key;
  logic [15:0][7:0] w_key_d;
  logic [3:0]       r_rnd;
  logic [3:0]       w_rnd_d;
  logic [15:0][7:0] r_plain;
  logic [15:0][7:0] w_plain_d;
  logic             r_done;
  logic             w_done_d;

  // State and datapath registers; reset wins over everything, including an in-flight block
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
      r_plain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_key   <= w_key_d;
      r_rnd   <= w_rnd_d;
      r_plain <= w_plain_d;
      r_done  <= w_done_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_key_d   = r_key;
    w_rnd_d   = r_rnd;
    w_plain_d = r_plain;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Inputs are sampled only here, so later changes cannot disturb the block
        if (bus.start) begin
          w_data_d  = bus.cipher_in ^ bus.key_in;
          w_key_d   = bus.key_in;
          w_rnd_d   = RndInit;
          w_state_d = StRound;
        end
      end
      StRound: begin
        w_data_d = bus.round_out;
        w_key_d  = bus.round_keyout;
        // Saturate at 1 so the round constant can never wrap
        w_rnd_d  = (r_rnd > 4'd1) ? r_rnd - 4'd1 : 4'd1;
        if (r_rnd <= 4'd2) begin
          w_state_d = StFinal;
        end
      end
      StFinal: begin
        w_plain_d = bus.final_out;
        w_done_d  = 1'b1;
        w_rnd_d   = 4'd0;
        w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // All outputs come straight from registers, so round_out never reaches an output directly
  assign bus.round_data = r_data;
  assign bus.round_key  = r_key;
  assign bus.round_rc   = r_rnd;
  assign bus.plain_out  = r_plain;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state == StRound) || (r_state == StFinal);

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: plays the external AES inverse-round datapath and key
// expansion, and compares results against a whole-block AES-128 decryption model.
module tb_aes_decrypt_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] FipsCipher = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsKey    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] FipsPlain  = 128'h00112233445566778899aabbccddeeff;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  aes_decrypt_ctrl_if u_if ();

  aes_decrypt_ctrl #(.NROUNDS(NR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES primitives (byte i of a block = AES byte i) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] get_b(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(r+4*c) -: 8] = get_b(x, r + 4 * ((c - r + 4) % 4));
    return y;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox(get_b(x, i));
    return y;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_b(x, 4*c);
      a1 = get_b(x, 4*c+1);
      a2 = get_b(x, 4*c+2);
      a3 = get_b(x, 4*c+3);
      y[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      y[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      y[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      y[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return y;
  endfunction

  function automatic logic [7:0] rcon(input int rc);
    logic [7:0] r;
    if (rc < 1) return 8'h00;
    r = 8'h01;
    for (int i = 1; i < rc; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Round key rc-1 from round key rc
  function automatic logic [127:0] prev_key(input logic [127:0] k, input int rc);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    t  = {p3[23:0], p3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    p0 = w0 ^ t ^ {rcon(rc), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Whole-block reference decryption from the last round key
  function automatic logic [127:0] ref_decrypt(input logic [127:0] c, input logic [127:0] k);
    logic [127:0] s;
    logic [127:0] key;
    s   = c ^ k;
    key = k;
    for (int r = NR; r >= 2; r--) begin
      key = prev_key(key, r);
      s   = inv_mix(inv_sub(inv_shift(s)) ^ key);
    end
    key = prev_key(key, 1);
    return inv_sub(inv_shift(s)) ^ key;
  endfunction

  // External datapath driven from the controller's outputs
  assign u_if.round_keyout = prev_key(u_if.round_key, int'(u_if.round_rc));
  assign u_if.round_out    = inv_mix(inv_sub(inv_shift(u_if.round_data)) ^ u_if.round_keyout);
  assign u_if.final_out    = inv_sub(inv_shift(u_if.round_data)) ^ u_if.round_keyout;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: plain, 1: scramble inputs after acceptance, 2: extra start pulse at cycle 4
  task automatic run_block(input logic [127:0] c, input logic [127:0] k, input int mode);
    logic [127:0] exp_plain;
    exp_plain      = ref_decrypt(c, k);
    u_if.cipher_in = c;
    u_if.key_in    = k;
    u_if.start     = 1'b1;
    tick();
    u_if.start = 1'b0;
    check_val("load_data", u_if.round_data, c ^ k);
    check_val("load_key", u_if.round_key, k);
    for (int t = 0; t <= NR; t++) begin
      check_val("rc", 128'(u_if.round_rc), (t < NR) ? 128'(NR - t) : 128'd0);
      check_val("busy", 128'(u_if.busy), (t < NR) ? 128'd1 : 128'd0);
      check_val("done", 128'(u_if.done), (t == NR) ? 128'd1 : 128'd0);
      if (t == NR) check_val("plain", u_if.plain_out, exp_plain);
      if (mode == 1) begin
        u_if.cipher_in = rand128();
        u_if.key_in    = rand128();
      end
      if (mode == 2) begin
        u_if.start = (t == 4);
        if (t == 4) begin
          u_if.cipher_in = rand128();
          u_if.key_in    = rand128();
        end
      end
      if (t < NR) tick();
    end
    u_if.start = 1'b0;
    tick();
    check_val("done_clear", 128'(u_if.done), 128'd0);
    check_val("idle_busy", 128'(u_if.busy), 128'd0);
    tick();
    check_val("no_queue", 128'(u_if.busy), 128'd0);
    check_val("plain_hold", u_if.plain_out, exp_plain);
  endtask

  initial begin
    logic [127:0] b_c, b_k, exp_b;
    int           n_done;
    n_total        = 0;
    n_bad          = 0;
    rst            = 1'b1;
    u_if.start     = 1'b0;
    u_if.cipher_in = '0;
    u_if.key_in    = '0;
    tick();
    tick();
    check_val("rst_busy", 128'(u_if.busy), 128'd0);
    check_val("rst_done", 128'(u_if.done), 128'd0);
    check_val("rst_plain", u_if.plain_out, 128'd0);
    check_val("rst_rc", 128'(u_if.round_rc), 128'd0);
    check_val("rst_data", u_if.round_data, 128'd0);
    check_val("rst_key", u_if.round_key, 128'd0);

    // Start on the first edge after reset releases
    rst = 1'b0;
    run_block(FipsCipher, FipsKey, 0);
    check_val("fips", u_if.plain_out, FipsPlain);

    // Start pulsed mid-operation is ignored
    run_block(FipsCipher, FipsKey, 2);
    check_val("fips_ignore", u_if.plain_out, FipsPlain);

    // Reset mid-operation
    u_if.cipher_in = rand128();
    u_if.key_in    = rand128();
    u_if.start     = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check_val("abort_busy", 128'(u_if.busy), 128'd0);
    check_val("abort_done", 128'(u_if.done), 128'd0);
    check_val("abort_plain", u_if.plain_out, 128'd0);
    check_val("abort_rc", 128'(u_if.round_rc), 128'd0);
    check_val("abort_data", u_if.round_data, 128'd0);
    check_val("abort_key", u_if.round_key, 128'd0);
    rst = 1'b0;
    run_block(FipsCipher, FipsKey, 0);
    check_val("fips_after_rst", u_if.plain_out, FipsPlain);

    // Start held high across two blocks
    b_c            = rand128();
    b_k            = rand128();
    exp_b          = ref_decrypt(b_c, b_k);
    u_if.cipher_in = FipsCipher;
    u_if.key_in    = FipsKey;
    u_if.start     = 1'b1;
    tick();
    u_if.cipher_in = b_c;
    u_if.key_in    = b_k;
    n_done         = 0;
    for (int t = 1; t <= 26; t++) begin
      tick();
      if (t == 13) u_if.start = 1'b0;
      if (u_if.done === 1'b1) begin
        if (n_done == 0) begin
          check_val("b2b_t0", 128'(t), 128'd10);
          check_val("b2b_p0", u_if.plain_out, FipsPlain);
        end else begin
          check_val("b2b_t1", 128'(t), 128'd22);
          check_val("b2b_p1", u_if.plain_out, exp_b);
        end
        n_done++;
      end
    end
    check_val("b2b_count", 128'(n_done), 128'd2);

    // Random blocks, alternately with inputs scrambled after acceptance
    for (int i = 0; i < 6; i++) run_block(rand128(), rand128(), i % 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_ctrl.md
AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

Interface
REQ-001 SHALL have parameter NROUNDS, default 10: total AES-128 decryption rounds, including the final round.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request to decrypt; sampled only in IDLE.
REQ-005 SHALL have port cipher_in, input, [15:0][7:0]: ciphertext block; byte 15 = bits 127:120 = first AES byte.
REQ-006 SHALL have port key_in, input, [15:0][7:0]: final (round-NROUNDS) round key, same byte order.
REQ-007 SHALL have port round_data, output, [15:0][7:0]: state fed to the external inverse-round datapath.
REQ-008 SHALL have port round_key, output, [15:0][7:0]: key fed to the inverse-round key expansion.
REQ-009 SHALL have port round_rc, output, [3:0]: round constant index fed to the key expansion.
REQ-010 SHALL have port round_out, input, [15:0][7:0]: inverse-round result (after inv sub, shift, mixcol and key add).
REQ-011 SHALL have port round_keyout, input, [15:0][7:0]: previous round key from the key expansion.
REQ-012 SHALL have port final_out, input, [15:0][7:0]: result of the external final round (no inv mixcol).
REQ-013 SHALL have port busy, output, 1: high while a block is in flight.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when plain_out is valid.
REQ-015 SHALL have port plain_out, output, [15:0][7:0]: decrypted block, held until the next completion or reset.

Function
REQ-016 SHALL implement the FSM states IDLE, ROUND, FINAL and DONE.
REQ-017 SHALL, in IDLE with start=1 on an edge, load state_reg <= cipher_in XOR key_in, key_reg <= key_in and rnd <= NROUNDS, then enter ROUND.
REQ-018 SHALL continuously drive round_data=state_reg, round_key=key_reg and round_rc=rnd, with no combinational path from round_out to any output.
REQ-019 SHALL, on each edge in ROUND, update state_reg <= round_out, key_reg <= round_keyout and rnd <= rnd-1.
REQ-020 SHALL leave ROUND for FINAL on the edge where rnd==2, so that ROUND lasts exactly NROUNDS-1 cycles with rc 10 down to 2.
REQ-021 SHALL, in FINAL, drive round_rc=1; on the edge it SHALL set plain_out <= final_out and done <= 1, then enter DONE.
REQ-022 SHALL make done high for exactly one cycle, in DONE, and SHALL return to IDLE on the following edge.
REQ-023 SHALL set latency so that done is visible after the 10th rising edge following the edge that samples start (NROUNDS=10).
REQ-024 SHALL make busy=1 in ROUND and FINAL and busy=0 in IDLE and DONE.
REQ-025 SHALL ignore start in ROUND, FINAL and DONE; there is no queueing, and the in-flight block is unaffected.
REQ-026 SHALL, if start is held high continuously, accept a new block every 12 cycles (IDLE, ROUND x9, FINAL, DONE).
REQ-027 SHALL sample cipher_in and key_in only at acceptance; later changes to them SHALL NOT affect the result.
REQ-028 SHALL hold rnd at 4 bits; it SHALL never wrap below 1 and SHALL hold 0 in IDLE and DONE.

Reset
REQ-029 SHALL, on an edge with rst=1, set state=IDLE, state_reg=0, key_reg=0, rnd=0, plain_out=0, done=0 and busy=0.
REQ-030 SHALL give rst priority over start and over all FSM activity, including reset mid-operation; the aborted block SHALL produce no done.
REQ-031 SHALL accept start on the first edge after rst deasserts.

Verification
REQ-032 SHALL cover the FIPS-197 vector: cipher 69c4e0d86a7b0430d8cdb78070b4c55a with key_in 13111d7fe3944a17f307a78b4d2b30c5 -> plain_out 00112233445566778899aabbccddeeff, done a single pulse 10 edges after start, busy high for 10 cycles.
REQ-033 SHALL cover a rc trace: monitor round_rc over the ROUND and FINAL cycles -> sequence 10,9,8,7,6,5,4,3,2,1, then 0.
REQ-034 SHALL cover start pulsed with different data at cycle 4 of an operation -> ignored, and the first result still equals 00112233445566778899aabbccddeeff.
REQ-035 SHALL cover rst asserted at cycle 6 of an operation -> no done, all outputs 0 next cycle, and a fresh start then yields the correct result.
REQ-036 SHALL cover start held high over two blocks -> two done pulses 12 cycles apart, with plain_out correct for each block.
REQ-037 SHALL cover cipher_in and key_in changing to random values immediately after acceptance -> plain_out unchanged from the expected value.
